// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: port count, port indices, select width,
// and the per-output allocation state type.
package noc_pkg;

    localparam int unsigned NPORT   = 5;
    localparam int unsigned SELW    = 3;

    localparam int unsigned PORT_E  = 0;
    localparam int unsigned PORT_W  = 1;
    localparam int unsigned PORT_N  = 2;
    localparam int unsigned PORT_S  = 3;
    localparam int unsigned PORT_EJ = 4;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_BUSY = 1'b1
    } out_state_t;

    // Keep only the lowest set bit of a request vector
    function automatic logic [NPORT-1:0] lowest_bit(input logic [NPORT-1:0] v);
        return v & (~v + NPORT'(1));
    endfunction

endpackage

// File: rtl/switch_alloc_rr_arb.sv
// NPORT-way combinational round-robin arbiter: the search starts one past
// the pointer (the last winner) and wraps modulo NPORT.
module rr_arb
    import noc_pkg::*;
(
    input  logic [NPORT-1:0] req,
    input  logic [SELW-1:0]  ptr,
    output logic [NPORT-1:0] gnt,
    output logic [SELW-1:0]  idx
);

    logic            found;
    logic [SELW-1:0] ci;

    // Scan ptr+1 .. ptr+NPORT and pick the first requester
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        ci    = '0;
        for (int unsigned k = 1; k <= NPORT; k++) begin
            ci = SELW'((32'(ptr) + k) % NPORT);
            if (!found && req[ci]) begin
                found   = 1'b1;
                gnt[ci] = 1'b1;
                idx     = ci;
            end
        end
    end

endmodule

// File: rtl/switch_alloc.sv
// Per-router switch allocator: round-robin per output on head flits,
// output locked to its winning input until the tail flit.
module switch_alloc
    import noc_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NPORT*NPORT-1:0] req,
    input  logic [NPORT-1:0]       flit_vld,
    input  logic [NPORT-1:0]       flit_tail,
    input  logic [NPORT-1:0]       out_rdy,
    output logic [NPORT-1:0]       gnt,
    output logic [NPORT-1:0]       out_vld,
    output logic [NPORT*SELW-1:0]  xbar_sel
);

    logic [NPORT-1:0] dreq    [NPORT];
    logic [NPORT-1:0] cand    [NPORT];
    logic [NPORT-1:0] arb_gnt [NPORT];
    logic [SELW-1:0]  arb_idx [NPORT];

    out_state_t       state_q [NPORT];
    out_state_t       state_d [NPORT];
    logic [SELW-1:0]  owner_q [NPORT];
    logic [SELW-1:0]  owner_d [NPORT];
    logic [SELW-1:0]  rr_q    [NPORT];
    logic [SELW-1:0]  rr_d    [NPORT];

    logic [NPORT-1:0] xfer;
    logic [SELW-1:0]  src     [NPORT];

    // Decode requests (lowest bit wins) and form per-output candidate vectors
    always_comb begin
        for (int unsigned i = 0; i < NPORT; i++) begin
            dreq[i] = lowest_bit(req[i*NPORT +: NPORT]);
        end
        for (int unsigned o = 0; o < NPORT; o++) begin
            for (int unsigned i = 0; i < NPORT; i++) begin
                cand[o][i] = flit_vld[i] & dreq[i][o];
            end
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_arb
        rr_arb u_arb (
            .req (cand[o]),
            .ptr (rr_q[o]),
            .gnt (arb_gnt[o]),
            .idx (arb_idx[o])
        );
    end

    // State, owner and pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned o = 0; o < NPORT; o++) begin
                state_q[o] <= OUT_IDLE;
                owner_q[o] <= '0;
                rr_q[o]    <= SELW'(NPORT - 1);
            end
        end else begin
            for (int unsigned o = 0; o < NPORT; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                rr_q[o]    <= rr_d[o];
            end
        end
    end

    // Next state: pointer moves only on head wins; lock released by tail
    always_comb begin
        for (int unsigned o = 0; o < NPORT; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            rr_d[o]    = rr_q[o];
            if (xfer[o]) begin
                case (state_q[o])
                    OUT_IDLE: begin
                        rr_d[o] = src[o];
                        if (!flit_tail[src[o]]) begin
                            state_d[o] = OUT_BUSY;
                            owner_d[o] = src[o];
                        end
                    end
                    OUT_BUSY: begin
                        if (flit_tail[owner_q[o]]) begin
                            state_d[o] = OUT_IDLE;
                        end
                    end
                    default: state_d[o] = OUT_IDLE;
                endcase
            end
        end
    end

    // Outputs: per-output transfer decision, then gnt as OR over outputs
    always_comb begin
        xfer     = '0;
        gnt      = '0;
        xbar_sel = '0;
        for (int unsigned o = 0; o < NPORT; o++) begin
            src[o] = '0;
            if (!reset) begin
                case (state_q[o])
                    OUT_IDLE: begin
                        if (out_rdy[o] && (|arb_gnt[o])) begin
                            xfer[o] = 1'b1;
                            src[o]  = arb_idx[o];
                        end
                    end
                    OUT_BUSY: begin
                        if (flit_vld[owner_q[o]] && out_rdy[o]) begin
                            xfer[o] = 1'b1;
                            src[o]  = owner_q[o];
                        end
                    end
                    default: ;
                endcase
            end
            xbar_sel[o*SELW +: SELW] = src[o];
            for (int unsigned i = 0; i < NPORT; i++) begin
                if (xfer[o] && (src[o] == SELW'(i))) begin
                    gnt[i] = 1'b1;
                end
            end
        end
        out_vld = xfer;
    end

endmodule

// File: tb/tb_switch_alloc.sv
// Directed bench for switch_alloc: expected outputs queued per cycle and
// checked on the falling edge.
module tb_switch_alloc;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [24:0] req;
    logic [4:0]  flit_vld;
    logic [4:0]  flit_tail;
    logic [4:0]  out_rdy;
    logic [4:0]  gnt;
    logic [4:0]  out_vld;
    logic [14:0] xbar_sel;

    typedef struct {
        string       tag;
        logic [4:0]  g;
        logic [4:0]  v;
        logic [14:0] s;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    switch_alloc dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .flit_vld  (flit_vld),
        .flit_tail (flit_tail),
        .out_rdy   (out_rdy),
        .gnt       (gnt),
        .out_vld   (out_vld),
        .xbar_sel  (xbar_sel)
    );

    function automatic logic [14:0] mk_sel(input logic [2:0] e, input logic [2:0] w,
                                           input logic [2:0] n, input logic [2:0] s,
                                           input logic [2:0] ej);
        return {ej, s, n, w, e};
    endfunction

    task automatic set_in(input int i, input logic [4:0] m, input logic v, input logic t);
        req[i*5 +: 5] = m;
        flit_vld[i]   = v;
        flit_tail[i]  = t;
    endtask

    task automatic clear_in();
        req       = '0;
        flit_vld  = '0;
        flit_tail = '0;
        out_rdy   = '1;
    endtask

    task automatic cyc(input string tag, input logic [4:0] g, input logic [4:0] v,
                       input logic [14:0] s);
        exp_t e;
        e.tag = tag;
        e.g   = g;
        e.v   = v;
        e.s   = s;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        n_chk++;
        assert (gnt === e.g) else begin
            n_fail++;
            $error("FAIL %s gnt: observed %b expected %b", e.tag, gnt, e.g);
        end
        n_chk++;
        assert (out_vld === e.v) else begin
            n_fail++;
            $error("FAIL %s out_vld: observed %b expected %b", e.tag, out_vld, e.v);
        end
        n_chk++;
        assert (xbar_sel === e.s) else begin
            n_fail++;
            $error("FAIL %s xbar_sel: observed %h expected %h", e.tag, xbar_sel, e.s);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every input active: outputs must stay quiet
        reset = 1'b1;
        clear_in();
        for (int i = 0; i < 5; i++) set_in(i, 5'(1 << i), 1'b1, 1'b1);
        cyc("rst0", 5'b00000, 5'b00000, 15'h0);
        cyc("rst1", 5'b00000, 5'b00000, 15'h0);

        // Round robin on E after reset: input 1 before input 3
        reset = 1'b0;
        clear_in();
        set_in(1, 5'b00001, 1'b1, 1'b1);
        set_in(3, 5'b00001, 1'b1, 1'b1);
        cyc("rr_e0", 5'b00010, 5'b00001, mk_sel(1, 0, 0, 0, 0));
        set_in(1, 5'b00000, 1'b0, 1'b0);
        cyc("rr_e1", 5'b01000, 5'b00001, mk_sel(3, 0, 0, 0, 0));

        // Four-flit packet from input 2 on N, input 0 competing from flit 2
        clear_in();
        set_in(2, 5'b00100, 1'b1, 1'b0);
        cyc("lock_n0", 5'b00100, 5'b00100, mk_sel(0, 0, 2, 0, 0));
        set_in(0, 5'b00100, 1'b1, 1'b1);
        cyc("lock_n1", 5'b00100, 5'b00100, mk_sel(0, 0, 2, 0, 0));
        cyc("lock_n2", 5'b00100, 5'b00100, mk_sel(0, 0, 2, 0, 0));
        set_in(2, 5'b00100, 1'b1, 1'b1);
        cyc("lock_n3", 5'b00100, 5'b00100, mk_sel(0, 0, 2, 0, 0));
        set_in(2, 5'b00000, 1'b0, 1'b0);
        cyc("turn_n", 5'b00001, 5'b00100, mk_sel(0, 0, 0, 0, 0));

        // S locked to input 4: stalls, resume, bubble, tail, then input 1
        clear_in();
        set_in(4, 5'b01000, 1'b1, 1'b0);
        cyc("s_head", 5'b10000, 5'b01000, mk_sel(0, 0, 0, 4, 0));
        out_rdy = 5'b10111;
        set_in(1, 5'b01000, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) cyc("s_stall", 5'b00000, 5'b00000, 15'h0);
        out_rdy = '1;
        cyc("s_resume", 5'b10000, 5'b01000, mk_sel(0, 0, 0, 4, 0));
        flit_vld[4] = 1'b0;
        cyc("s_bubble", 5'b00000, 5'b00000, 15'h0);
        set_in(4, 5'b01000, 1'b1, 1'b1);
        cyc("s_tail", 5'b10000, 5'b01000, mk_sel(0, 0, 0, 4, 0));
        set_in(4, 5'b00000, 1'b0, 1'b0);
        cyc("s_wrap", 5'b00010, 5'b01000, mk_sel(0, 0, 0, 1, 0));

        // All five inputs to distinct outputs in one cycle
        clear_in();
        for (int i = 0; i < 5; i++) set_in(i, 5'(1 << i), 1'b1, 1'b1);
        cyc("all5", 5'b11111, 5'b11111, mk_sel(0, 1, 2, 3, 4));

        // Reset drops the W lock held by input 4
        clear_in();
        set_in(4, 5'b00010, 1'b1, 1'b0);
        cyc("w_head", 5'b10000, 5'b00010, mk_sel(0, 4, 0, 0, 0));
        reset = 1'b1;
        set_in(0, 5'b00010, 1'b1, 1'b1);
        cyc("w_rst", 5'b00000, 5'b00000, 15'h0);
        reset = 1'b0;
        set_in(4, 5'b00000, 1'b0, 1'b0);
        cyc("w_after", 5'b00001, 5'b00010, mk_sel(0, 0, 0, 0, 0));

        // Malformed request 00101 from input 2 counts as E only
        clear_in();
        set_in(2, 5'b00101, 1'b1, 1'b1);
        set_in(0, 5'b00100, 1'b1, 1'b1);
        cyc("malformed", 5'b00101, 5'b00101, mk_sel(2, 0, 0, 0, 0));

        // No transfer while the output is not ready
        clear_in();
        set_in(0, 5'b00001, 1'b1, 1'b1);
        out_rdy = 5'b11110;
        cyc("e_notrdy", 5'b00000, 5'b00000, 15'h0);
        out_rdy = '1;
        cyc("e_rdy", 5'b00001, 5'b00001, mk_sel(0, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
